// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU operation sequencer.
// Opcode/operand/result widths, FSM states, queued op bundle.
package alu_pkg;

  localparam int OPCODE_W  = 2;
  localparam int OPERAND_W = 3;
  localparam int RESULT_W  = 6;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
  } op_t;

endpackage

// File: rtl/alu_op_fifo.sv
// Circular operation queue, DEPTH entries (power of two).
// Pointers wrap naturally; pushes while full are dropped.
module alu_op_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  op_t                    din,
  input  logic                   pop,
  output op_t                    dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  op_t           mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Feeds queued ops to a fixed-latency ALU one at a time
// and holds each result until the consumer takes it.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPCODE_W-1:0]    in_opcode,
  input  logic [OPERAND_W-1:0]   in_a,
  input  logic [OPERAND_W-1:0]   in_b,
  output logic [OPCODE_W-1:0]    opcode,
  output logic [OPERAND_W-1:0]   portA,
  output logic [OPERAND_W-1:0]   portB,
  input  logic [RESULT_W-1:0]    alu_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [RESULT_W-1:0]    res_data,
  output logic [OPCODE_W-1:0]    res_opcode,
  output logic [$clog2(DEPTH):0] count
);

  localparam int TW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  state_t        state;
  state_t        state_d;
  logic [TW-1:0] timer;
  logic          pop;
  logic          capture;
  logic          release_res;
  logic          full;
  logic          empty;
  op_t           din;
  op_t           head;

  assign din      = '{opcode: in_opcode, a: in_a, b: in_b};
  assign in_ready = !full;

  alu_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d     = state;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (timer == '0) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          release_res = 1'b1;
          pop         = !empty;
          state_d     = empty ? IDLE : WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU ports only change on an issue edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode     <= '0;
      portA      <= '0;
      portB      <= '0;
      timer      <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_opcode <= '0;
    end else begin
      if (pop) begin
        opcode <= head.opcode;
        portA  <= head.a;
        portB  <= head.b;
        timer  <= TW'(ALU_LAT);
      end else if (state == WAIT && timer != '0) begin
        timer <= timer - 1'b1;
      end
      if (capture) begin
        res_valid  <= 1'b1;
        res_data   <= alu_out;
        res_opcode <= opcode;
      end else if (release_res) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a one-stage
// registered ALU model (add, mul, sub, concat).
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_opcode = '0;
  logic [2:0] in_a = '0;
  logic [2:0] in_b = '0;
  logic [1:0] opcode;
  logic [2:0] portA;
  logic [2:0] portB;
  logic [5:0] alu_out = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [5:0] res_data;
  logic [1:0] res_opcode;
  logic [2:0] count;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [13:0] vec [10];

  logic mon_en = 1'b0;
  logic prev_v = 1'b0;
  int   highs = 0;
  int   consec = 0;

  alu_op_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .opcode     (opcode),
    .portA      (portA),
    .portB      (portB),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_opcode (res_opcode),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] alu_f(
    input logic [1:0] op,
    input logic [2:0] a,
    input logic [2:0] b
  );
    case (op)
      2'd0:    return 6'(a) + 6'(b);
      2'd1:    return 6'(a) * 6'(b);
      2'd2:    return 6'(a) - 6'(b);
      default: return {a, b};
    endcase
  endfunction

  always @(posedge clk) alu_out <= alu_f(opcode, portA, portB);

  task automatic chk(
    input string name,
    input logic [31:0] got,
    input logic [31:0] want
  );
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Scoreboard monitor: compare on every result handshake
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got op=%0d data=%0d",
                 res_opcode, res_data);
      end else begin
        chk("result", {24'd0, res_opcode, res_data},
            {24'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (res_valid) highs++;
      if (res_valid && prev_v) consec++;
      prev_v = res_valid;
    end
  end

  task automatic drive(input int idx);
    in_valid  = 1'b1;
    in_opcode = vec[idx][13:12];
    in_a      = vec[idx][11:9];
    in_b      = vec[idx][8:6];
  endtask

  // Offers n consecutive vectors, one per cycle, from posedge+1
  task automatic push_seq(
    input int first,
    input int n,
    output int nacc
  );
    logic acc;
    int idx;
    nacc = 0;
    for (int k = 0; k < n; k++) begin
      idx = (first + k) % 10;
      drive(idx);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        exp_q.push_back({vec[idx][13:12], vec[idx][5:0]});
        nacc++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && count == 0 && !res_valid)
        done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got pending=%0d want 0",
               name, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nacc;
    int saw;
    logic got_v;
    vec = '{
      {2'd1, 3'd4, 3'd3, 6'd12},
      {2'd0, 3'd7, 3'd7, 6'd14},
      {2'd2, 3'd2, 3'd5, 6'd61},
      {2'd3, 3'd5, 3'd2, 6'd42},
      {2'd1, 3'd7, 3'd6, 6'd42},
      {2'd2, 3'd6, 3'd1, 6'd5},
      {2'd0, 3'd3, 3'd4, 6'd7},
      {2'd3, 3'd1, 3'd7, 6'd15},
      {2'd1, 3'd5, 3'd5, 6'd25},
      {2'd2, 3'd0, 3'd1, 6'd63}
    };

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_ports", {26'd0, opcode, portA, portB}, 0);
    chk("rst_res", {24'd0, res_opcode, res_data}, 0);

    // Single op latency
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    drive(0);
    exp_q.push_back({vec[0][13:12], vec[0][5:0]});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t1_opcode", 32'(opcode), 1);
    chk("t1_portA", 32'(portA), 4);
    chk("t1_portB", 32'(portB), 3);
    @(posedge clk);
    @(negedge clk);
    chk("t2_res_valid", 32'(res_valid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t3_res_valid", 32'(res_valid), 1);
    chk("t3_res_data", 32'(res_data), 12);
    chk("t3_res_opcode", 32'(res_opcode), 1);
    wait_drain("single");

    // Backpressure until full
    res_ready = 1'b0;
    push_seq(1, 6, nacc);
    chk("bp_accepted", 32'(nacc), 5);
    @(negedge clk);
    chk("bp_count", 32'(count), 4);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_res_valid", 32'(res_valid), 1);
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_drain("bp");

    // Back-to-back issue with one result per valid window
    highs  = 0;
    consec = 0;
    prev_v = 1'b0;
    mon_en = 1'b1;
    push_seq(7, 3, nacc);
    wait_drain("b2b");
    mon_en = 1'b0;
    chk("b2b_valid_cycles", 32'(highs), 3);
    chk("b2b_adjacent", 32'(consec), 0);

    // Wrap-around: ten single push/drain rounds
    for (int r = 0; r < 10; r++) begin
      push_seq(r, 1, nacc);
      wait_drain("wrap");
    end
    chk("wrap_count", 32'(count), 0);

    // Push and pop on the same edge at count 2
    res_ready = 1'b0;
    push_seq(2, 3, nacc);
    got_v = 1'b0;
    for (int i = 0; i < 20 && !got_v; i++) begin
      @(posedge clk);
      #1;
      got_v = res_valid;
    end
    chk("sim_hold_seen", 32'(got_v), 1);
    chk("sim_count_pre", 32'(count), 2);
    res_ready = 1'b1;
    drive(5);
    exp_q.push_back({vec[5][13:12], vec[5][5:0]});
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("sim_count_post", 32'(count), 2);
    wait_drain("sim");

    // Reset during WAIT with two queued
    res_ready = 1'b0;
    push_seq(0, 3, nacc);
    chk("mid_count", 32'(count), 2);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_count_rst", 32'(count), 0);
    chk("mid_ports_rst", {26'd0, opcode, portA, portB}, 0);
    chk("mid_res_rst", {24'd0, res_opcode, res_data}, 0);
    chk("mid_valid_rst", 32'(res_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    res_ready = 1'b1;
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid) saw++;
    end
    chk("post_rst_valid", 32'(saw), 0);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_count", 32'(count), 0);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter ALU_LAT, default 1, number of ALU clock edges from operands stable to alu_out stable.
REQ-003 SHALL use one clock and reset: clk  in  1  rising-edge clock shared with the ALU.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  producer offers an operation.
REQ-006 SHALL have port in_ready  out  1  queue can accept.
REQ-007 SHALL have port in_opcode  in  2  operation code.
REQ-008 SHALL have port in_a  in  3  operand A.
REQ-009 SHALL have port in_b  in  3  operand B.
REQ-010 SHALL have port opcode  out  2  to ALU opcode.
REQ-011 SHALL have port portA  out  3  to ALU portA.
REQ-012 SHALL have port portB  out  3  to ALU portB.
REQ-013 SHALL have port alu_out  in  6  from ALU out.
REQ-014 SHALL have port res_valid  out  1  result available.
REQ-015 SHALL have port res_ready  in  1  consumer accepts result.
REQ-016 SHALL have port res_data  out  6  captured ALU result.
REQ-017 SHALL have port res_opcode  out  2  opcode that produced res_data.
REQ-018 SHALL have port count  out  clog2(DEPTH)+1  queue occupancy, 0..DEPTH.

Function
REQ-019 SHALL push {in_opcode,in_a,in_b} on an edge with in_valid && in_ready; in_ready = (count < DEPTH), registered-state only, no combinational path from in_valid.
REQ-020 SHALL run FSM states IDLE, WAIT, HOLD.
REQ-021 IDLE: count>0 -> pop head, register it onto opcode/portA/portB, load timer = ALU_LAT, go WAIT; else stay.
REQ-022 WAIT: timer decrements each edge; on the edge where timer==0, capture alu_out into res_data, opcode into res_opcode, set res_valid, go HOLD (capture = ALU_LAT+1 edges after issue).
REQ-023 HOLD: res_valid, res_data, res_opcode stable until res_ready; on edge with res_ready: if count>0 pop and issue next (back to WAIT, res_valid low next cycle), else clear res_valid, go IDLE.
REQ-024 SHALL hold opcode/portA/portB unchanged from issue edge until next issue edge.
REQ-025 Latency: push into empty idle queue at edge t0 -> ALU ports valid after t1 -> res_valid high after t1+ALU_LAT+1 (t3 for ALU_LAT=1).
REQ-026 Simultaneous push and pop in same edge SHALL leave count unchanged and preserve FIFO order.
REQ-027 Push into empty queue SHALL NOT be issued in the same edge (issue earliest next edge).
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
REQ-029 in_valid while full SHALL be ignored (no overwrite, no count change).
REQ-030 res_ready while res_valid low SHALL have no effect.

Reset
REQ-031 rst high SHALL immediately force: state IDLE, count 0, pointers 0, opcode/portA/portB 0, res_valid 0, res_data 0, res_opcode 0, timer 0; in_ready 1 after release.
REQ-032 Reset mid-operation SHALL discard queued entries and in-flight result; no result emitted for them after release.

Structure
REQ-033 Shared package alu_pkg SHALL hold OPCODE_W=2, OPERAND_W=3, RESULT_W=6, and the FSM state enum.
REQ-034 Storage SHALL be sub-module alu_op_fifo (push/pop/count/full/empty); FSM and result register in alu_op_sequencer.

Verification
REQ-035 Single op: reset, push (op=1,a=4,b=3) at t0 -> opcode=1,portA=4,portB=3 after t1; res_valid=1 after t3, res_data = ALU result for (1,4,3), res_opcode=1.
REQ-036 Backpressure/full: res_ready=0, push 6 ops -> first issued, 4 queued, count=4, in_ready=0, 6th not accepted; release res_ready -> remaining 4 results in push order.
REQ-037 Back-to-back: 3 ops queued, res_ready=1 -> each result occupies exactly one res_valid cycle, one idle gap per op, order preserved.
REQ-038 Wrap-around: 10 push/drain cycles with DEPTH=4 -> all 10 results correct and in order, count returns to 0.
REQ-039 Reset mid-op: assert rst during WAIT with 2 queued -> all outputs 0 immediately; after release no res_valid without new push.
REQ-040 Simultaneous push/pop at count=2 -> count stays 2, ordering checked against scoreboard.
